// File: rtl/rs_encode_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_encode_sched_pkg
//  Description : Shared types and constants for the Reed-Solomon encode
//                scheduler: FSM state encoding, bus word width and the
//                default message/codeword sizes.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_encode_sched_pkg;

  localparam int C_WORD_W        = 32;
  localparam int C_DEF_IN_WORDS  = 42;
  localparam int C_DEF_OUT_WORDS = 50;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_DRAIN = 3'd5
  } rs_sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rs_encode_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : rs_encode_sched_if
//  Description : Requester-fabric bus of the encode scheduler: request/grant,
//                input word stream and codeword output stream.
//  Ports       : master - requester fabric side (drives requests, input words,
//                         output ready)
//                slave  - scheduler side (drives grant, in_ready, codeword
//                         stream with last flag and owner id)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rs_encode_sched_if
  import rs_encode_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ-1:0]         grant_o;
  logic                       in_valid_i;
  logic [C_WORD_W-1:0]        in_data_i;
  logic                       in_ready_o;
  logic                       out_valid_o;
  logic [C_WORD_W-1:0]        out_data_o;
  logic                       out_last_o;
  logic [$clog2(NUM_REQ)-1:0] out_id_o;
  logic                       out_ready_i;

  modport master (
    output req_valid_i, in_valid_i, in_data_i, out_ready_i,
    input  grant_o, in_ready_o, out_valid_o, out_data_o, out_last_o, out_id_o
  );

  modport slave (
    input  req_valid_i, in_valid_i, in_data_i, out_ready_i,
    output grant_o, in_ready_o, out_valid_o, out_data_o, out_last_o, out_id_o
  );

endinterface
`default_nettype wire

// File: rtl/rs_encode_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rs_rr_arbiter
//  Description : Combinational round-robin pick. Selects the first asserted
//                request at or after rr_ptr in circular order.
//  Ports       : req    in  NUM_REQ          - request vector
//                rr_ptr in  $clog2(NUM_REQ)  - highest-priority index
//                gnt    out NUM_REQ          - one-hot grant (0 if no request)
//                idx    out $clog2(NUM_REQ)  - index of the granted request
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_rr_arbiter
  import rs_encode_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  wire logic [NUM_REQ-1:0]         req,
  input  wire logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic      [NUM_REQ-1:0]         gnt,
  output logic      [$clog2(NUM_REQ)-1:0] idx
);

  localparam int             IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] C_NUM = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_idx;

  // Offsets are scanned from farthest to nearest so the nearest requester at
  // or after rr_ptr is the last one written and therefore wins.
  always_comb begin
    w_idx  = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (w_sum >= C_NUM) begin
        w_sum = w_sum - C_NUM;
      end
      w_cand = w_sum[IDX_W-1:0];
      if (req[w_cand]) begin
        w_idx = w_cand;
      end
    end
  end

  assign idx = w_idx;
  assign gnt = (|req) ? (NUM_REQ'(1) << w_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/rs_encode_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rs_encode_sched
//  Description : Shares one Reed-Solomon encode core among NUM_REQ requesters.
//                Round-robin grant, streams IN_WORDS message words into the
//                core load buffer, pulses core clear, holds encode enable
//                until the core reports valid (or a timeout aborts the job),
//                then streams the captured codeword back as OUT_WORDS words.
//  Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//                bus (slave)         - request/grant, input and output streams
//                busy_o              - scheduler not idle
//                err_o               - one-cycle pulse on timeout abort
//                core_clrn_o         - core clear, active-low
//                core_encode_en_o    - core encode enable
//                core_datain_o       - message load buffer, word 0 in LSBs
//                core_ready_i        - core idle/ready
//                core_valid_i        - core codeword valid
//                core_encoded_i      - core codeword, word 0 in LSBs
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_encode_sched
  import rs_encode_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IN_WORDS  = C_DEF_IN_WORDS,
  parameter int OUT_WORDS = C_DEF_OUT_WORDS,
  parameter int TIMEOUT   = 1024
) (
  input  wire logic                            clk_i,
  input  wire logic                            rst_i,
  rs_encode_sched_if.slave                     bus,
  output logic                                 busy_o,
  output logic                                 err_o,
  output logic                                 core_clrn_o,
  output logic                                 core_encode_en_o,
  output logic [C_WORD_W*IN_WORDS-1:0]         core_datain_o,
  input  wire logic                            core_ready_i,
  input  wire logic                            core_valid_i,
  input  wire logic [C_WORD_W*OUT_WORDS-1:0]   core_encoded_i
);

  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int IN_CNT_W  = $clog2(IN_WORDS);
  localparam int OUT_CNT_W = $clog2(OUT_WORDS);
  localparam int TO_W      = $clog2(TIMEOUT);

  localparam logic [IN_CNT_W-1:0]  C_IN_LAST  = IN_CNT_W'(IN_WORDS - 1);
  localparam logic [OUT_CNT_W-1:0] C_OUT_LAST = OUT_CNT_W'(OUT_WORDS - 1);
  localparam logic [TO_W-1:0]      C_TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]     C_IDX_LAST = IDX_W'(NUM_REQ - 1);

  rs_sched_state_e                  r_state;
  logic [IDX_W-1:0]                 r_rr_ptr;
  logic [NUM_REQ-1:0]               r_grant;
  logic [IDX_W-1:0]                 r_gidx;
  logic [IN_CNT_W-1:0]              r_in_cnt;
  logic [OUT_CNT_W-1:0]             r_out_cnt;
  logic [TO_W-1:0]                  r_to_cnt;
  logic                             r_err;
  logic [C_WORD_W*IN_WORDS-1:0]     r_load_buf;
  logic [C_WORD_W*OUT_WORDS-1:0]    r_out_buf;

  logic [NUM_REQ-1:0]               w_arb_gnt;
  logic [IDX_W-1:0]                 w_arb_idx;
  logic [IDX_W-1:0]                 w_next_ptr;
  logic                             w_load_acc;
  logic [C_WORD_W-1:0]              w_out_words [OUT_WORDS];

  rs_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (bus.req_valid_i),
    .rr_ptr (r_rr_ptr),
    .gnt    (w_arb_gnt),
    .idx    (w_arb_idx)
  );

  // Priority moves to the requester just after the one that was served.
  assign w_next_ptr = (r_gidx == C_IDX_LAST) ? '0 : r_gidx + 1'b1;
  assign w_load_acc = (r_state == S_LOAD) && bus.in_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
      r_out_buf <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req_valid_i) begin
            r_grant  <= w_arb_gnt;
            r_gidx   <= w_arb_idx;
            r_in_cnt <= '0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.in_valid_i) begin
            if (r_in_cnt == C_IN_LAST) begin
              r_state <= S_CLEAR;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_state <= S_START;
        end
        S_START: begin
          if (core_ready_i) begin
            r_to_cnt <= '0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A valid arriving on the last allowed cycle still completes the job.
          if (core_valid_i) begin
            r_out_buf <= core_encoded_i;
            r_out_cnt <= '0;
            r_state   <= S_DRAIN;
          end else if (r_to_cnt == C_TO_LAST) begin
            r_err    <= 1'b1;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (bus.out_ready_i) begin
            if (r_out_cnt == C_OUT_LAST) begin
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
              r_state  <= S_IDLE;
            end else begin
              r_out_cnt <= r_out_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // One write port per message word keeps every slice select constant.
  for (genvar w = 0; w < IN_WORDS; w++) begin : g_load_word
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_load_buf[w*C_WORD_W +: C_WORD_W] <= '0;
      end else if (w_load_acc && (r_in_cnt == IN_CNT_W'(w))) begin
        r_load_buf[w*C_WORD_W +: C_WORD_W] <= bus.in_data_i;
      end
    end
  end

  for (genvar w = 0; w < OUT_WORDS; w++) begin : g_out_word
    assign w_out_words[w] = r_out_buf[w*C_WORD_W +: C_WORD_W];
  end

  // Stream-side outputs decode registered state only, so neither in_valid_i
  // nor out_ready_i reaches an output combinationally.
  assign bus.grant_o      = r_grant;
  assign bus.in_ready_o   = (r_state == S_LOAD);
  assign bus.out_valid_o  = (r_state == S_DRAIN);
  assign bus.out_data_o   = (r_state == S_DRAIN) ? w_out_words[r_out_cnt] : '0;
  assign bus.out_last_o   = (r_state == S_DRAIN) && (r_out_cnt == C_OUT_LAST);
  assign bus.out_id_o     = r_gidx;
  assign busy_o           = (r_state != S_IDLE);
  assign err_o            = r_err;
  assign core_clrn_o      = (r_state != S_CLEAR);
  assign core_encode_en_o = (r_state == S_WAIT);
  assign core_datain_o    = r_load_buf;

endmodule
`default_nettype wire

// File: tb/tb_rs_encode_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_encode_sched
//  Description : Self-checking bench for rs_encode_sched with a stub encode
//                core and a scoreboard queue of expected codeword words.
//  Ports       : none (top-level bench)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_encode_sched;
  import rs_encode_sched_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int IN_WORDS  = 42;
  localparam int OUT_WORDS = 50;
  localparam int TIMEOUT   = 1024;
  localparam int STUB_LAT  = 10;

  logic clk = 1'b0;
  logic rst;
  logic busy, err, clrn, enc_en, core_ready;
  logic core_valid = 1'b0;
  logic [32*IN_WORDS-1:0]  datain;
  logic [32*OUT_WORDS-1:0] encoded;
  logic [31:0] code_base = 32'h0;
  bit          stub_never = 1'b0;
  int          stub_cnt = 0;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q [$];

  rs_encode_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  rs_encode_sched #(
    .NUM_REQ   (NUM_REQ),
    .IN_WORDS  (IN_WORDS),
    .OUT_WORDS (OUT_WORDS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .bus              (bus.slave),
    .busy_o           (busy),
    .err_o            (err),
    .core_clrn_o      (clrn),
    .core_encode_en_o (enc_en),
    .core_datain_o    (datain),
    .core_ready_i     (core_ready),
    .core_valid_i     (core_valid),
    .core_encoded_i   (encoded)
  );

  always #5 clk = ~clk;

  // Stub core: one-cycle valid STUB_LAT cycles after encode enable rises.
  always @(posedge clk) begin
    if (!enc_en) begin
      stub_cnt   <= 0;
      core_valid <= 1'b0;
    end else begin
      stub_cnt   <= stub_cnt + 1;
      core_valid <= !stub_never && (stub_cnt == STUB_LAT - 1);
    end
  end

  for (genvar g = 0; g < OUT_WORDS; g++) begin : g_code
    assign encoded[g*32 +: 32] = code_base + 32'(g);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [32*IN_WORDS-1:0] obs,
                          input logic [32*IN_WORDS-1:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_grant"},     bus.grant_o,     0);
    chk({tag, "_in_ready"},  bus.in_ready_o,  0);
    chk({tag, "_out_valid"}, bus.out_valid_o, 0);
    chk({tag, "_out_last"},  bus.out_last_o,  0);
    chk({tag, "_out_data"},  bus.out_data_o,  0);
    chk({tag, "_out_id"},    bus.out_id_o,    0);
    chk({tag, "_busy"},      busy,            0);
    chk({tag, "_err"},       err,             0);
    chk({tag, "_encode_en"}, enc_en,          0);
    chk({tag, "_clrn"},      clrn,            1);
    chk_wide({tag, "_load_buf"}, datain, '0);
  endtask

  // One complete job for requester id. Called at a negedge with the request
  // already driven; returns at the negedge after the job ends.
  task automatic run_job(input int id, input int gap_pct, input int stall_pct,
                         input int ready_delay, input bit timeout_job,
                         input int abort_at, input bit rand_data, input bit drop_req,
                         input logic [31:0] base);
    logic [32*IN_WORDS-1:0] exp_buf;
    logic [31:0] word, prev_data, exp_w;
    bit v, rdy, stalled, prev_cv, got;
    int k, hs, waited, guard;

    code_base  = base;
    stub_never = timeout_job;
    if (ready_delay > 0) core_ready = 1'b0;
    if (!timeout_job) begin
      for (int j = 0; j < OUT_WORDS; j++) exp_q.push_back(base + 32'(j));
    end

    waited = 0; got = 1'b0;
    while (!got && waited < 50) begin
      @(negedge clk); waited++;
      got = (bus.grant_o != '0);
    end
    chk("grant_latency", waited, 1);
    chk("grant_onehot", bus.grant_o, 64'(1) << id);
    chk("in_ready", bus.in_ready_o, 1);
    chk("busy", busy, 1);
    if (drop_req) bus.req_valid_i = '0;

    k = 0; guard = 0;
    while (k < IN_WORDS && guard < 2000) begin
      v    = ($urandom_range(99) >= gap_pct);
      word = rand_data ? $urandom : 32'(k + 1);
      bus.in_valid_i = v;
      bus.in_data_i  = word;
      rdy = bus.in_ready_o;
      @(posedge clk);
      if (v && rdy) begin
        exp_buf[k*32 +: 32] = word;
        k++;
      end
      @(negedge clk); guard++;
    end
    bus.in_valid_i = 1'b0;
    chk("load_count", k, IN_WORDS);
    chk("clrn_low", clrn, 0);
    chk("in_ready_off", bus.in_ready_o, 0);
    chk_wide("load_buf", datain, exp_buf);
    @(negedge clk);
    chk("clrn_one_cycle", clrn, 1);

    for (int d = 0; d < ready_delay; d++) begin
      chk("encode_en_wait_ready", enc_en, 0);
      @(negedge clk);
    end
    core_ready = 1'b1;

    waited = 0;
    while (!enc_en && waited < 100) begin @(negedge clk); waited++; end
    chk("encode_en_rise", waited, 1);

    if (timeout_job) begin
      waited = 0;
      while (!err && waited < TIMEOUT + 10) begin @(negedge clk); waited++; end
      chk("timeout_cycles", waited, TIMEOUT);
      chk("timeout_grant", bus.grant_o, 0);
      chk("timeout_encode_en", enc_en, 0);
      chk("timeout_busy", busy, 0);
      @(negedge clk);
      chk("err_single_pulse", err, 0);
      stub_never = 1'b0;
      return;
    end

    waited = 0; prev_cv = 1'b0;
    while (!bus.out_valid_o && waited < 200) begin
      prev_cv = core_valid;
      @(negedge clk); waited++;
    end
    chk("core_valid_to_out", prev_cv, 1);
    chk("out_latency", waited, STUB_LAT + 1);
    chk("encode_en_drop", enc_en, 0);

    hs = 0; stalled = 1'b0; guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      guard++;
      if (hs == abort_at) begin
        rst = 1'b1;
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        chk_reset("abort");
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      bus.out_ready_i = ($urandom_range(99) >= stall_pct);
      chk("out_valid", bus.out_valid_o, 1);
      if (stalled) chk("stall_stable", bus.out_data_o, prev_data);
      if (bus.out_ready_i) begin
        exp_w = exp_q.pop_front();
        chk("out_data", bus.out_data_o, exp_w);
        chk("out_last", bus.out_last_o, (hs == OUT_WORDS - 1));
        chk("out_id", bus.out_id_o, id);
        hs++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        prev_data = bus.out_data_o;
      end
      @(negedge clk);
    end
    bus.out_ready_i = 1'b0;
    chk("drain_count", hs, OUT_WORDS);
    chk("grant_release", bus.grant_o, 0);
    chk("busy_release", busy, 0);
    chk("out_valid_release", bus.out_valid_o, 0);
  endtask

  initial begin
    rst             = 1'b1;
    core_ready      = 1'b1;
    bus.req_valid_i = '0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single job, requester 2, message words k+1, stub codeword 0xC0DE0000+j.
    bus.req_valid_i = 4'b0100;
    run_job(2, 0, 0, 0, 1'b0, -1, 1'b0, 1'b1, 32'hC0DE_0000);

    // Fresh reset so rr_ptr restarts at 0, then all four requesters held high.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_job(i % NUM_REQ, 0, 0, 0, 1'b0, -1, 1'b0, (i == 4), 32'h1000_0000 * 32'(i + 1));
    end

    // Random input gaps and output stalls on requester 1.
    bus.req_valid_i = 4'b0010;
    run_job(1, 30, 50, 0, 1'b0, -1, 1'b1, 1'b1, 32'hA5A5_0000);

    // Core never answers: requester 2 times out, requester 3 is served next.
    bus.req_valid_i = 4'b1111;
    run_job(2, 0, 0, 0, 1'b1, -1, 1'b0, 1'b0, 32'h2222_0000);
    run_job(3, 0, 0, 0, 1'b0, -1, 1'b0, 1'b1, 32'h3333_0000);

    // Core not ready for 20 cycles in START.
    bus.req_valid_i = 4'b0001;
    run_job(0, 0, 0, 20, 1'b0, -1, 1'b0, 1'b1, 32'h4444_0000);

    // Reset mid-drain at word 17; the next job starts from requester 0.
    bus.req_valid_i = 4'b0010;
    run_job(1, 0, 0, 0, 1'b0, 17, 1'b0, 1'b1, 32'h5555_0000);
    bus.req_valid_i = 4'b1111;
    run_job(0, 0, 0, 0, 1'b0, -1, 1'b1, 1'b1, 32'h6666_0000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
